// File: rtl/boot_rom_if.sv
// boot_rom_if: adapter between the core req/gnt/rvalid boot-address slot and the
// 548x32 boot ROM macro (CSN/A/Q, registered address, 1-cycle read).
// Holds the response under rready backpressure, flags write, misaligned and
// out-of-range accesses, and keeps a saturating error count.
// Optional feature: define BOOT_ROM_LOCK_EN to add lock_i. A pulse on lock_i
// sets a sticky lock that turns every later access into an error until RST.
// The ROM macro's own RSTN is tied to ~RST one level up.
module boot_rom_if #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           ROM_ADDR_WIDTH = 10,
    parameter int unsigned           ROM_DEPTH      = 548,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_8000
) (
    input  logic                      CLK,
    input  logic                      RST,
`ifdef BOOT_ROM_LOCK_EN
    input  logic                      lock_i,
`endif
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    input  logic                      rready_i,
    output logic [7:0]                err_cnt_o,
    output logic                      rom_csn_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]               rom_rdata_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP_OK  = 2'd1,
        RESP_ERR = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ROM_DEPTH_W = ADDR_WIDTH'(ROM_DEPTH);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  locked;
    logic                  ok;
    logic [7:0]            err_cnt_q;

    // Word index relative to the ROM base; the low bits drive the macro address.
    assign offset     = addr_i - BASE_ADDR;
    assign idx        = offset >> 2;
    assign rom_addr_o = idx[ROM_ADDR_WIDTH-1:0];

`ifdef BOOT_ROM_LOCK_EN
    logic locked_q;

    // Sticky boot-done lock: set by any lock_i pulse, cleared only by RST.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values of its inputs.
        if (RST) begin
            locked_q <= 1'b0;
        end else if (lock_i) begin
            locked_q <= 1'b1;
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    // An access is serviceable only for aligned, in-range reads while unlocked.
    assign ok = !we_i
             && (addr_i[1:0] == 2'b00)
             && (addr_i >= BASE_ADDR)
             && (idx < ROM_DEPTH_W)
             && !locked;

    // State register: holds which kind of response is currently presented.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a grant loads a new response, rready alone retires the old one.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (gnt_o) begin
            state_d = ok ? RESP_OK : RESP_ERR;
        end else if (rready_i) begin
            state_d = IDLE;
        end
    end

    // Outputs: grant when the response slot is free or retiring this cycle;
    // the ROM is strobed only for serviceable granted accesses, so a held
    // response keeps the ROM-latched address and hence rdata stable.
    always_comb begin
        gnt_o     = req_i && !RST && ((state_q == IDLE) || rready_i);
        rom_csn_o = !(gnt_o && ok);
        rvalid_o  = (state_q != IDLE);
        err_o     = (state_q == RESP_ERR);
        rdata_o   = (state_q == RESP_OK) ? rom_rdata_i : 32'h0;
    end

    // Saturating count of error responses, one per granted bad access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_q <= 8'h00;
        end else if (gnt_o && !ok && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule
